// File: rtl/sort_stream_adapter_pkg.sv
// Shared widths, FSM encoding and nibble helpers for the sort stream adapter.
package sort_stream_adapter_pkg;

  localparam int NUM_COUNT = 8;
  localparam int NUM_W     = 4;
  localparam int IDX_W     = $clog2(NUM_COUNT);
  localparam int WORD_W    = NUM_COUNT * NUM_W;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [NUM_W-1:0]  num_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_COUNT - 1);

  function automatic num_t get_num(input word_t word, input idx_t k);
    return word[NUM_W*k +: NUM_W];
  endfunction

endpackage

// File: rtl/sort_stream_adapter_nibble_serializer.sv
// Holds the sorted word and replays it smallest-first over a valid/ready stream.
module sort_stream_adapter_nibble_serializer
  import sort_stream_adapter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  capture,
  input  word_t sorted,
  input  logic  active,
  input  logic  ready,
  output logic  valid,
  output num_t  data,
  output logic  last,
  output logic  done
);

  word_t result;
  idx_t  idx;

  // NOTE: result is a plain register, not a memory, so it is reset along with idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      idx    <= '0;
    end else begin
      if (capture) result <= sorted;
      // idx wraps 7 -> 0 on the final accept, ready for the next frame
      if (active && ready) idx <= idx + 1'b1;
    end
  end

  assign valid = active;
  assign data  = get_num(result, idx);
  assign last  = active && (idx == LAST_IDX);
  assign done  = active && ready && (idx == LAST_IDX);

endmodule

// File: rtl/sort_stream_adapter.sv
// Stream front/back end for the 8x4-bit counting sorter.
// Optional WAIT timeout with sticky err_o is enabled by defining SORT_ADAPTER_TIMEOUT_EN.
module sort_stream_adapter
  import sort_stream_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [3:0]  in_data_i,
  output logic        in_ready_o,
  output logic        sort_start_o,
  output logic [31:0] sort_nums_o,
  input  logic        sort_valid_i,
  input  logic [31:0] sort_nums_i,
  output logic        out_valid_o,
  output logic [3:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  state_t state;
  idx_t   load_idx;
  word_t  nums;
  logic   capture;
  logic   drain_done;
  logic   timeout;

  assign capture = (state == ST_WAIT) && sort_valid_i;

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_LOAD;
      load_idx <= '0;
      nums     <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_valid_i) begin
            nums[NUM_W*load_idx +: NUM_W] <= in_data_i;
            load_idx <= load_idx + 1'b1;
            if (load_idx == LAST_IDX) state <= ST_START;
          end
        end
        ST_START: state <= ST_ARM;
        // the sorter's valid from the previous frame is still up here
        ST_ARM:   state <= ST_WAIT;
        ST_WAIT: begin
          if (sort_valid_i) state <= ST_DRAIN;
          else if (timeout) state <= ST_LOAD;
        end
        ST_DRAIN: if (drain_done) state <= ST_LOAD;
        default:  state <= ST_LOAD;
      endcase
    end
  end

`ifdef SORT_ADAPTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout) err <= 1'b1;
    end
  end

  assign timeout = (state == ST_WAIT) && !sort_valid_i && (wait_cnt == CNT_LAST);
  assign err_o   = err;
`else
  assign timeout = 1'b0;
  // constant 0: TIMEOUT_CYCLES only matters when the timeout is built in
  assign err_o   = (TIMEOUT_CYCLES < 0);
`endif

  sort_stream_adapter_nibble_serializer u_serializer (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .capture (capture),
    .sorted  (sort_nums_i),
    .active  (state == ST_DRAIN),
    .ready   (out_ready_i),
    .valid   (out_valid_o),
    .data    (out_data_o),
    .last    (out_last_o),
    .done    (drain_done)
  );

  assign in_ready_o   = (state == ST_LOAD);
  assign sort_start_o = (state == ST_START);
  assign busy_o       = (state != ST_LOAD);
  assign sort_nums_o  = nums;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Scoreboard bench for sort_stream_adapter with a behavioural stub sorter.
module tb_sort_stream_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [3:0]  in_data_i;
  logic        in_ready_o;
  logic        sort_start_o;
  logic [31:0] sort_nums_o;
  logic        sort_valid_i;
  logic [31:0] sort_nums_i;
  logic        out_valid_o;
  logic [3:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  sort_stream_adapter #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .sort_start_o (sort_start_o),
    .sort_nums_o  (sort_nums_o),
    .sort_valid_i (sort_valid_i),
    .sort_nums_i  (sort_nums_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frames_done = 0;
  int   frames_expected = 0;
  bit   stub_silent = 1'b0;
  int   stub_delay = 24;
  int   ready_mode = 0;
  bit   noise = 1'b0;
  bit   in_flight = 1'b0;
  bit   check_idle_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sort: histogram of the eight values, re-emitted smallest first.
  function automatic logic [31:0] sort_word(input logic [31:0] w);
    int cnt[16];
    int pos = 0;
    logic [31:0] r = '0;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 8; i++) cnt[w[4*i +: 4]]++;
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < cnt[v]; c++) begin
        r[4*pos +: 4] = v[3:0];
        pos++;
      end
    return r;
  endfunction

  // Stub sorter: valid is a level that stays up until the cycle after the next start.
  initial begin : stub
    logic [31:0] got;
    int d;
    forever begin
      @(negedge clk_i);
      if (sort_start_o) begin
        if (stub_silent) begin
          sort_valid_i = 1'b0;
        end else begin
          got = sort_word(sort_nums_o);
          d = stub_delay;
          @(negedge clk_i);
          @(negedge clk_i);
          if (d > 0) begin
            sort_valid_i = 1'b0;
            repeat (d) @(negedge clk_i);
          end
          check("no_early_capture", out_valid_o, 1'b0);
          sort_valid_i = 1'b1;
          sort_nums_i  = got;
          @(negedge clk_i);
          check("out_valid_after_capture", out_valid_o, 1'b1);
        end
      end
    end
  end

  int bp_phase = 0;
  initial begin : ready_drv
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        1:       out_ready_i = (bp_phase % 3 == 0);
        2:       out_ready_i = 1'($urandom % 2);
        default: out_ready_i = 1'b1;
      endcase
      bp_phase++;
    end
  end

  initial begin : monitor
    exp_t e;
    logic prev_stall = 1'b0;
    logic [3:0] prev_data = '0;
    logic prev_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (check_idle_next) begin
        check("in_ready_after_drain", in_ready_o, 1'b1);
        check("busy_after_drain", busy_o, 1'b0);
        check_idle_next = 1'b0;
      end
      if (in_flight) check("in_ready_low_in_frame", in_ready_o, 1'b0);
      if (prev_stall) begin
        check("stall_data_stable", out_data_o, prev_data);
        check("stall_last_stable", out_last_o, prev_last);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h, expected no nibble", out_data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data_o, e.data);
          check("out_last", out_last_o, e.last);
          if (e.last) begin
            frames_done++;
            in_flight = 1'b0;
            check_idle_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [3:0] v[8], input int gap, input bit expect_out);
    int k = 0;
    int cyc = 0;
    logic [31:0] packed_w = '0;
    logic [31:0] s;
    for (int i = 0; i < 8; i++) packed_w[4*i +: 4] = v[i];
    while (k < 8 && cyc < 200) begin
      @(posedge clk_i);
      #1;
      if (cyc % gap == 0) begin
        in_valid_i = 1'b1;
        in_data_i  = v[k];
        if (in_ready_o) k++;
      end else begin
        in_valid_i = 1'b0;
        in_data_i  = 4'($urandom);
      end
      cyc++;
    end
    check("load_accepts", k, 8);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("start_pulse", sort_start_o, 1'b1);
    check("sort_nums_at_start", sort_nums_o, packed_w);
    in_flight = 1'b1;
    if (expect_out) begin
      s = sort_word(packed_w);
      for (int i = 0; i < 8; i++) exp_q.push_back('{data: s[4*i +: 4], last: (i == 7)});
      frames_expected++;
    end
    @(negedge clk_i);
    check("start_single_cycle", sort_start_o, 1'b0);
  endtask

  task automatic wait_frames();
    int guard = 0;
    while (frames_done < frames_expected && guard < 1000) begin
      @(posedge clk_i);
      #1;
      in_valid_i = noise && !in_ready_o && ($urandom % 2 == 1);
      in_data_i  = 4'($urandom);
      guard++;
    end
    in_valid_i = 1'b0;
    check("frame_drained", frames_done, frames_expected);
  endtask

  task automatic rand_frame(output logic [3:0] v[8]);
    for (int i = 0; i < 8; i++) v[i] = 4'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready_o, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_sort_start"}, sort_start_o, 1'b0);
    check({tag, "_out_valid"}, out_valid_o, 1'b0);
    check({tag, "_out_last"}, out_last_o, 1'b0);
    check({tag, "_out_data"}, out_data_o, 4'h0);
    check({tag, "_sort_nums"}, sort_nums_o, 32'h0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] fr[8];
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    sort_valid_i = 1'b0;
    sort_nums_i = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check_idle("reset");

    // Basic sort with a 24-cycle sorter
    fr = '{4'h8, 4'h3, 4'hF, 4'h0, 4'h3, 4'h1, 4'h7, 4'h2};
    stub_delay = 24;
    send_frame(fr, 1, 1'b1);
    check("basic_packed_word", sort_nums_o, 32'h2713_0F38);
    wait_frames();

    // Backpressure 1,0,0 during DRAIN
    ready_mode = 1;
    rand_frame(fr);
    stub_delay = 5;
    send_frame(fr, 1, 1'b1);
    wait_frames();

    // Input every third cycle, junk valid while busy
    ready_mode = 0;
    noise = 1'b1;
    rand_frame(fr);
    stub_delay = 0;
    send_frame(fr, 3, 1'b1);
    wait_frames();

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      ready_mode = $urandom_range(0, 2);
      stub_delay = $urandom_range(0, 30);
      noise = 1'($urandom % 2);
      rand_frame(fr);
      send_frame(fr, $urandom_range(1, 3), 1'b1);
      wait_frames();
    end
    noise = 1'b0;
    ready_mode = 0;
    check("err_after_frames", err_o, 1'b0);

    // Reset while waiting on the sorter
    stub_silent = 1'b1;
    rand_frame(fr);
    send_frame(fr, 1, 1'b0);
    repeat (4) @(negedge clk_i);
    check("in_wait_busy", busy_o, 1'b1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    in_flight = 1'b0;
    @(negedge clk_i);
    check_idle("mid_wait_reset");
    stub_silent = 1'b0;
    stub_delay = 7;
    for (int i = 0; i < 8; i++) fr[i] = 4'h7;
    send_frame(fr, 1, 1'b1);
    wait_frames();

    // Silent sorter: timeout behaviour
    stub_silent = 1'b1;
    rand_frame(fr);
    send_frame(fr, 1, 1'b0);
    repeat (64) @(negedge clk_i);
    check("pre_timeout_err", err_o, 1'b0);
    check("pre_timeout_busy", busy_o, 1'b1);
    @(posedge clk_i);
    #1 in_flight = 1'b0;
    @(negedge clk_i);
`ifdef SORT_ADAPTER_TIMEOUT_EN
    check("timeout_err", err_o, 1'b1);
    check("timeout_busy", busy_o, 1'b0);
    check("timeout_in_ready", in_ready_o, 1'b1);
    stub_silent = 1'b0;
    stub_delay = 3;
    rand_frame(fr);
    send_frame(fr, 1, 1'b1);
    wait_frames();
    check("err_sticky", err_o, 1'b1);
`else
    check("no_timeout_err", err_o, 1'b0);
    check("no_timeout_busy", busy_o, 1'b1);
    repeat (100) @(negedge clk_i);
    check("still_waiting_busy", busy_o, 1'b1);
    check("still_waiting_valid", out_valid_o, 1'b0);
    check("still_waiting_err", err_o, 1'b0);
`endif
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    in_flight = 1'b0;
    @(negedge clk_i);
    check("final_reset_err", err_o, 1'b0);
    check("final_reset_in_ready", in_ready_o, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_stream_adapter.md
# sort_stream_adapter

Stream front/back end for the 8×4-bit counting sorter. Accepts eight 4-bit numbers one at a time over a valid/ready input stream and packs them into a 32-bit word. It then drives the sorter's start/nums inputs and waits for the sorter's valid. Finally it captures the sorted word and replays it smallest-first over a valid/ready output stream. Sits between the input source (UART/switch debouncer) and the `sorting` instance on one side, and the display/transmit logic on the other.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles allowed in WAIT before abort. Used only with the timeout macro.

Ports:
- `clk_i` input 1: single clock, all logic rising-edge.
- `rst_i` input 1: reset, synchronous, active-low (asserted when 0).
- `in_valid_i` input 1: input nibble valid.
- `in_data_i` input 4: input number.
- `in_ready_o` output 1: adapter accepts a nibble this cycle.
- `sort_start_o` output 1: start pulse to the sorter.
- `sort_nums_o` output 32: packed numbers to the sorter; number k at bits [4k+3:4k].
- `sort_valid_i` input 1: sorter done (level).
- `sort_nums_i` input 32: sorted numbers from the sorter, smallest at [3:0].
- `out_valid_o` output 1: output nibble valid.
- `out_data_o` output 4: output number.
- `out_last_o` output 1: marks the 8th output nibble.
- `out_ready_i` input 1: downstream accepts.
- `busy_o` output 1: high in every state except LOAD.
- `err_o` output 1: sticky timeout flag.

## Operation
States, 3-bit: LOAD, START, ARM, WAIT, DRAIN. Reset state is LOAD.

- **LOAD:** `in_ready_o`=1.
  - On `in_valid_i && in_ready_o`, write `in_data_i` into `sort_nums_o[4*idx+:4]` and increment the 3-bit `idx`.
  - On the accept with idx==7, wrap idx to 0 and go to START.
- **START:** `sort_start_o`=1 for exactly one cycle, then go to ARM. `sort_nums_o` is held stable from START until the next LOAD accept.
- **ARM:** one cycle; `sort_valid_i` is ignored. This covers the sorter's stale valid, which clears one cycle after start. Then go to WAIT.
- **WAIT:** on `sort_valid_i`=1, register `sort_nums_i` into `result` and go to DRAIN.
- **DRAIN:**
  - Outputs: `out_valid_o`=1, `out_data_o`=`result[4*idx+:4]`, `out_last_o`=(idx==7).
  - On `out_valid_o && out_ready_i`, increment idx.
  - On the accept with idx==7, set idx to 0 and go to LOAD.
- **Output stability:** `out_data_o`/`out_last_o` must not change while `out_valid_o && !out_ready_i`.
- **Decode:** all stream and status outputs decode from the registered state and idx. There is no combinational path from inputs to outputs.

## Timing
- **Reset values:** state=LOAD, idx=0, `sort_nums_o`=0, `result`=0, `err_o`=0, `sort_start_o`=0, `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `busy_o`=0, `in_ready_o`=1.
- **Input side:** one nibble per cycle maximum; gaps in `in_valid_i` are allowed anywhere.
- **Start timing:** the cycle after the 8th input accept is START. ARM is START+1. WAIT begins at START+2.
- **Sort capture:** `result` is written on the WAIT cycle where `sort_valid_i`=1. `out_valid_o` rises the next cycle.
- **Output side:** with `out_ready_i` held high, the 8 nibbles leave in 8 consecutive cycles. `in_ready_o` returns to 1 the cycle after the last output accept.
- **Reset mid-operation:** reset taken in any state returns everything to the reset values the next cycle. Partially loaded numbers and pending results are discarded.
- **Ignored inputs:** `in_valid_i` outside LOAD is ignored (not accepted). `sort_valid_i` outside WAIT is ignored.

## Configuration
Macro: `SORT_ADAPTER_TIMEOUT_EN`.

- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT and clears on entering WAIT.
  - On reaching TIMEOUT_CYCLES without `sort_valid_i`, set `err_o`=1, discard the frame, and go to LOAD with idx=0.
  - `err_o` stays set until reset.
- **Not defined:** no counter exists; WAIT lasts indefinitely and `err_o` is tied to 0.

## Structure
- **Shared definitions in `def.v`:** state encodings, NUM_COUNT=8, NUM_W=4, and the nibble-slice macros already used for the sorter bit fields.
- **Sub-module `nibble_serializer`:** the natural split for the DRAIN datapath. It holds `result` and idx, and owns the valid/ready/last logic. The top keeps the FSM, the packer and the timeout.
- The sorter itself is instantiated outside this block.

## Test plan
- **Basic sort:** input 8,3,F,0,3,1,7,2 back-to-back with a stub sorter returning after 24 cycles. Expect `sort_nums_o`=0x2713_0F38 at START, a single-cycle `sort_start_o`, and output 0,1,2,3,3,7,8,F with `out_last_o` only on F.
- **Stale valid:** hold `sort_valid_i`=1 from the previous frame through START/ARM. The adapter must not capture until after ARM and must take the new result.
- **Backpressure:** toggle `out_ready_i` 1,0,0,1,… during DRAIN. Data stays stable while stalled, no nibble is lost or duplicated, and exactly 8 accepts occur.
- **Input gaps:** `in_valid_i` high every third cycle. Exactly 8 accepts occur, and `in_ready_o`=0 from START until DRAIN completes.
- **Reset mid-WAIT:** apply `rst_i`=0 for 1 cycle in WAIT. Next cycle state is LOAD, `busy_o`=0, `in_ready_o`=1, and a following frame of all-7s sorts to 7×8.
- **Timeout:** with `SORT_ADAPTER_TIMEOUT_EN` defined and the sorter stubbed silent, `err_o` rises exactly 64 cycles after entering WAIT and the adapter returns to LOAD. Without the macro it remains in WAIT with `err_o`=0.
